// File: rtl/i2c_slave_rx_pkg.sv
// Shared constants and state encoding for the I2C slave receive engine.
// Used by i2c_slave_rx and the START/STOP detector.
package i2c_slave_rx_pkg;

    localparam int         BYTE_W            = 8;
    localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_DATA_ACK  = 3'd4;
    localparam logic [2:0] S_WAIT_STOP = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        ADDR      = S_ADDR,
        ADDR_ACK  = S_ADDR_ACK,
        DATA      = S_DATA,
        DATA_ACK  = S_DATA_ACK,
        WAIT_STOP = S_WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_slave_rx_bus_cond.sv
// START/STOP detector on filtered SCL level and SDA edge pulses.
// Combinational; the caller registers the results as needed.
module i2c_bus_cond (
    input  logic i_scl_f,
    input  logic i_sda_pe,
    input  logic i_sda_ne,
    output logic o_start,
    output logic o_stop
);

    assign o_start = i_sda_ne & i_scl_f;
    assign o_stop  = i_sda_pe & i_scl_f;

endmodule

// File: rtl/i2c_slave_rx.sv
// Byte-level I2C slave receiver: address match, ACK/NACK, valid/ready bytes.
// Define I2C_GENERAL_CALL_EN to also ACK the general-call address 7'h00.
module i2c_slave_rx
    import i2c_slave_rx_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_f,
    input  logic              scl_pe,
    input  logic              scl_ne,
    input  logic              sda_f,
    input  logic              sda_pe,
    input  logic              sda_ne,
    output logic              sda_low,
    output logic              start_det,
    output logic              stop_det,
    output logic              busy,
    output logic              addr_match,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun
);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [BYTE_W-1:0] r_sreg;
    logic              r_ack;
    logic              r_drive;
    logic              r_sda_low;
    logic              r_start_det;
    logic              r_stop_det;
    logic              r_busy;
    logic              r_addr_match;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_overrun;

    logic              w_start;
    logic              w_stop;
    logic              w_addr_hit;
    logic              w_last_bit;
    logic              w_can_load;
    logic [BYTE_W-1:0] w_byte;

    i2c_bus_cond u_cond (
        .i_scl_f  (scl_f),
        .i_sda_pe (sda_pe),
        .i_sda_ne (sda_ne),
        .o_start  (w_start),
        .o_stop   (w_stop)
    );

`ifdef I2C_GENERAL_CALL_EN
    assign w_addr_hit = !r_sreg[0] &&
                        ((r_sreg[7:1] == SLAVE_ADDR) ||
                         (r_sreg[7:1] == GENERAL_CALL_ADDR));
`else
    assign w_addr_hit = !r_sreg[0] && (r_sreg[7:1] == SLAVE_ADDR);
`endif

    assign w_last_bit = (r_cnt == 4'd7);
    assign w_byte     = {r_sreg[BYTE_W-2:0], sda_f};
    assign w_can_load = !r_rx_valid || rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_sreg       <= '0;
            r_ack        <= 1'b0;
            r_drive      <= 1'b0;
            r_sda_low    <= 1'b0;
            r_start_det  <= 1'b0;
            r_stop_det   <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_match <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_start_det <= w_start;
            r_stop_det  <= w_stop && !w_start;
            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;

            if (w_start) begin
                r_state      <= ADDR;
                r_cnt        <= 4'd0;
                r_drive      <= 1'b0;
                r_sda_low    <= 1'b0;
                r_addr_match <= 1'b0;
                r_busy       <= 1'b1;
            end else if (w_stop) begin
                r_state      <= IDLE;
                r_drive      <= 1'b0;
                r_sda_low    <= 1'b0;
                r_addr_match <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_sda_low <= 1'b0;
                    end
                    ADDR, DATA: begin
                        if (scl_pe) begin
                            r_sreg <= w_byte;
                            r_cnt  <= r_cnt + 4'd1;
                            if (w_last_bit) begin
                                r_drive <= 1'b0;
                                r_state <= (r_state == ADDR) ? ADDR_ACK
                                                             : DATA_ACK;
                            end
                            // A byte is taken only if the holding slot frees up
                            if (w_last_bit && r_state == DATA) begin
                                r_ack <= w_can_load;
                                if (w_can_load) begin
                                    r_rx_data  <= w_byte;
                                    r_rx_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_ne) begin
                            if (!r_drive) begin
                                r_drive   <= 1'b1;
                                r_ack     <= w_addr_hit;
                                r_sda_low <= w_addr_hit;
                            end else begin
                                r_drive   <= 1'b0;
                                r_sda_low <= 1'b0;
                                r_cnt     <= 4'd0;
                                if (r_ack) begin
                                    r_addr_match <= 1'b1;
                                    r_state      <= DATA;
                                end else begin
                                    r_state <= WAIT_STOP;
                                end
                            end
                        end
                    end
                    DATA_ACK: begin
                        if (scl_ne) begin
                            if (!r_drive) begin
                                r_drive   <= 1'b1;
                                r_sda_low <= r_ack;
                                if (!r_ack)
                                    r_overrun <= 1'b1;
                            end else begin
                                r_drive   <= 1'b0;
                                r_sda_low <= 1'b0;
                                r_cnt     <= 4'd0;
                                r_state   <= r_ack ? DATA : WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: begin
                        r_sda_low <= 1'b0;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_low    = r_sda_low;
    assign start_det  = r_start_det;
    assign stop_det   = r_stop_det;
    assign busy       = r_busy;
    assign addr_match = r_addr_match;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx driving filtered SCL/SDA with edge pulses.
// Expected values are hand-computed from the I2C protocol behaviour.
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_f = 1'b1, scl_pe = 1'b0, scl_ne = 1'b0;
    logic       sda_f = 1'b1, sda_pe = 1'b0, sda_ne = 1'b0;
    logic       sda_low, start_det, stop_det, busy, addr_match;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;

    int n_chk = 0;
    int n_pass = 0;
    int start_cnt = 0;
    int stop_cnt = 0;
    int valid_cyc = 0;
    logic [7:0] seen_data = 8'h00;

    i2c_slave_rx #(.SLAVE_ADDR(7'h42)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_f      (scl_f),
        .scl_pe     (scl_pe),
        .scl_ne     (scl_ne),
        .sda_f      (sda_f),
        .sda_pe     (sda_pe),
        .sda_ne     (sda_ne),
        .sda_low    (sda_low),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy),
        .addr_match (addr_match),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_det) start_cnt++;
        if (stop_det)  stop_cnt++;
        if (rx_valid) begin
            valid_cyc++;
            seen_data = rx_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_set(input logic v);
        @(negedge clk);
        if (v != scl_f) begin
            scl_f  = v;
            scl_pe = v;
            scl_ne = !v;
        end
        @(negedge clk);
        scl_pe = 1'b0;
        scl_ne = 1'b0;
        idle(2);
    endtask

    task automatic sda_set(input logic v);
        @(negedge clk);
        if (v != sda_f) begin
            sda_f  = v;
            sda_pe = v;
            sda_ne = !v;
        end
        @(negedge clk);
        sda_pe = 1'b0;
        sda_ne = 1'b0;
        idle(2);
    endtask

    task automatic do_start();
        sda_set(1'b1);
        scl_set(1'b1);
        sda_set(1'b0);
        scl_set(1'b0);
    endtask

    task automatic do_stop();
        sda_set(1'b0);
        scl_set(1'b1);
        sda_set(1'b1);
    endtask

    task automatic send_bit(input logic b);
        sda_set(b);
        scl_set(1'b1);
        scl_set(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    int s0, p0, v0;
    logic gc_exp;

    initial begin
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_sda_low", sda_low, 0);
        check("rst_start_det", start_det, 0);
        check("rst_stop_det", stop_det, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_match", addr_match, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_overrun", overrun, 0);

        // matched address 0x42 write
        s0 = start_cnt;
        do_start();
        check("t1_start_pulses", start_cnt - s0, 1);
        check("t1_busy", busy, 1);
        send_byte(8'h84);
        check("t1_ack_low", sda_low, 1);
        scl_set(1'b1);
        check("t1_ack_high", sda_low, 1);
        scl_set(1'b0);
        check("t1_ack_release", sda_low, 0);
        check("t1_addr_match", addr_match, 1);
        p0 = stop_cnt;
        do_stop();
        check("t1_stop_busy", busy, 0);
        check("t1_stop_match", addr_match, 0);
        check("t1_stop_pulses", stop_cnt - p0, 1);

        // mismatched address 0x43 write
        do_start();
        send_byte(8'h86);
        check("t2_nack_low", sda_low, 0);
        scl_set(1'b1);
        check("t2_nack_high", sda_low, 0);
        scl_set(1'b0);
        check("t2_no_match", addr_match, 0);
        send_byte(8'h5A);
        check("t2_ignored_valid", rx_valid, 0);
        scl_set(1'b1);
        check("t2_wait_stop_sda", sda_low, 0);
        scl_set(1'b0);
        p0 = stop_cnt;
        do_stop();
        check("t2_busy", busy, 0);
        check("t2_stop_pulses", stop_cnt - p0, 1);

        // single data byte with consumer ready
        rx_ready = 1'b1;
        do_start();
        send_byte(8'h84);
        scl_set(1'b1);
        scl_set(1'b0);
        v0 = valid_cyc;
        send_byte(8'hA5);
        check("t3_valid_cycles", valid_cyc - v0, 1);
        check("t3_seen_data", seen_data, 8'hA5);
        check("t3_rx_data", rx_data, 8'hA5);
        check("t3_ack_low", sda_low, 1);
        scl_set(1'b1);
        scl_set(1'b0);
        check("t3_ack_release", sda_low, 0);
        do_stop();
        check("t3_busy", busy, 0);
        check("t3_overrun", overrun, 0);

        // two bytes with consumer stalled
        rx_ready = 1'b0;
        do_start();
        send_byte(8'h84);
        scl_set(1'b1);
        scl_set(1'b0);
        send_byte(8'h11);
        check("t4_b1_ack", sda_low, 1);
        check("t4_b1_valid", rx_valid, 1);
        check("t4_b1_data", rx_data, 8'h11);
        scl_set(1'b1);
        scl_set(1'b0);
        send_byte(8'h22);
        check("t4_b2_nack", sda_low, 0);
        check("t4_overrun", overrun, 1);
        check("t4_data_held", rx_data, 8'h11);
        scl_set(1'b1);
        scl_set(1'b0);
        do_stop();
        check("t4_valid_kept", rx_valid, 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(1);
        check("t4_consumed", rx_valid, 0);
        check("t4_overrun_sticky", overrun, 1);

        // repeated START mid data byte, then reset in ACK slot
        do_start();
        send_byte(8'h84);
        scl_set(1'b1);
        scl_set(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        s0 = start_cnt;
        sda_set(1'b1);
        scl_set(1'b1);
        sda_set(1'b0);
        scl_set(1'b0);
        check("t5_rs_pulse", start_cnt - s0, 1);
        check("t5_rs_match_clr", addr_match, 0);
        send_byte(8'h84);
        check("t5_ack_low", sda_low, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_sda", sda_low, 0);
        reset = 1'b0;
        idle(1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_overrun", overrun, 0);
        check("t5_rst_match", addr_match, 0);
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_data", rx_data, 0);

        // general call address
        scl_set(1'b1);
        sda_set(1'b1);
`ifdef I2C_GENERAL_CALL_EN
        gc_exp = 1'b1;
`else
        gc_exp = 1'b0;
`endif
        do_start();
        send_byte(8'h00);
        check("t6_gc_ack", sda_low, gc_exp);
        scl_set(1'b1);
        scl_set(1'b0);
        check("t6_gc_match", addr_match, gc_exp);
        do_stop();
        check("t6_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
